seq_divider_32bit: RTL and testbench

SEQ_DIVIDER_32BIT -- requirements
Module: seq_divider_32bit

---
 rtl/seq_divider_32bit.sv | 140 ++++++++++++++
 tb/tb_seq_divider_32bit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32bit.sv
// Sequential 32-bit restoring divider: 32 shift-subtract steps per divide.
// Define SEQ_DIV_SIGNED_EN to add two's-complement support via signed_i.
module seq_divider_32bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        div_by_zero_o
);

`ifdef SEQ_DIV_SIGNED_EN
    localparam int unsigned W = 33;
`else
    localparam int unsigned W = 32;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [4:0]     count;
    logic [31:0]    quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   dvs;
    logic           zero_div;
    logic           accept;
    logic [31:0]    mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic [W-1:0]   rem_nxt;
    logic [31:0]    quo_nxt;
    logic [31:0]    q_fin;
    logic [31:0]    r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic           neg_q;
    logic           neg_r;
`else
    logic           unused_signed;
    assign unused_signed = signed_i;
`endif

    assign accept = (state == IDLE) && start_i;

    always_comb begin
        mag_a = dividend_i;
        mag_b = W'(divisor_i);
`ifdef SEQ_DIV_SIGNED_EN
        if (signed_i && dividend_i[31]) mag_a = -dividend_i;
        if (signed_i && divisor_i[31])  mag_b = W'(-divisor_i);
`endif
    end

    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[W]) begin
            rem_nxt = diff[W-1:0];
            quo_nxt = {quo[30:0], 1'b1};
        end else begin
            rem_nxt = shifted[W-1:0];
            quo_nxt = {quo[30:0], 1'b0};
        end
        q_fin = quo_nxt;
        r_fin = rem_nxt[31:0];
`ifdef SEQ_DIV_SIGNED_EN
        if (neg_q) q_fin = -quo_nxt;
        if (neg_r) r_fin = -rem_nxt[31:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // A zero divisor still passes through RUN for one cycle so its done
    // pulse lands one edge after acceptance.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN:  if (zero_div || count == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count         <= '0;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            zero_div      <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
`endif
        end else if (accept) begin
            count         <= '0;
            quo           <= (divisor_i == '0) ? dividend_i : mag_a;
            rem           <= '0;
            dvs           <= mag_b;
            zero_div      <= (divisor_i == '0);
            div_by_zero_o <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q         <= signed_i & (dividend_i[31] ^ divisor_i[31]);
            neg_r         <= signed_i & dividend_i[31];
`endif
        end else if (state == RUN) begin
            if (zero_div) begin
                quotient_o    <= '1;
                remainder_o   <= quo;
                div_by_zero_o <= 1'b1;
            end else begin
                quo   <= quo_nxt;
                rem   <= rem_nxt;
                count <= count + 5'd1;
                if (count == 5'd31) begin
                    quotient_o  <= q_fin;
                    remainder_o <= r_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: vector table plus start-while-busy,
// mid-run reset and reset-vs-start corner sequences.
module tb_seq_divider_32bit;

`ifdef SEQ_DIV_SIGNED_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    int errors = 0;
    int checks = 0;

    seq_divider_32bit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .signed_i     (signed_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts one divide; counts done pulses over 40 edges after acceptance.
    // inj > 0 pulses start_i with 9/3 so that edge N+inj samples it.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int inj, output int lat, output int ndone);
        @(negedge clk_i);
        signed_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        dividend_i = 32'hDEADBEEF; divisor_i = '0; signed_i = ~s;
        check("busy_after_accept", 32'(busy_o), 32'd1);
        check("dz_cleared_at_accept", 32'(div_by_zero_o), 32'd0);
        lat = 0; ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                ndone++;
                if (lat == 0) lat = i;
            end
            if (inj > 0 && i == inj - 1) begin
                start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3; signed_i = 1'b0;
            end
            if (inj > 0 && i == inj) start_i = 1'b0;
        end
    endtask

    initial begin
        int lat, nd, cnt;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        SE ? 32'hFFFFFFFD : 32'h7FFFFFFC, SE ? 32'hFFFFFFFF : 32'd1, 1'b0};
        vecs[2]  = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
        vecs[3]  = '{1'b0, 32'd5,         32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, SE ? 32'h80000000 : 32'd0, SE ? 32'd0 : 32'h80000000, 1'b0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[7]  = '{1'b0, 32'd3,         32'd10,       32'd0,        32'd3,        1'b0};
        vecs[8]  = '{1'b1, 32'd7,         32'hFFFFFFFE, SE ? 32'hFFFFFFFD : 32'd0, SE ? 32'd1 : 32'd7, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, SE ? 32'd14 : 32'd0, SE ? 32'hFFFFFFFE : 32'hFFFFFF9C, 1'b0};
        vecs[10] = '{1'b0, 32'h12345678,  32'h00001000, 32'h00012345, 32'h00000678, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_q", quotient_o, 32'd0);
        check("rst_r", remainder_o, 32'd0);
        check("rst_dz", 32'(div_by_zero_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int v = 0; v < 12; v++) begin
            run_div(vecs[v].sgn, vecs[v].a, vecs[v].b, 0, lat, nd);
            check($sformatf("v%0d_latency", v), 32'(lat), (vecs[v].b == '0) ? 32'd1 : 32'd32);
            check($sformatf("v%0d_done_count", v), 32'(nd), 32'd1);
            check($sformatf("v%0d_q", v), quotient_o, vecs[v].q);
            check($sformatf("v%0d_r", v), remainder_o, vecs[v].r);
            check($sformatf("v%0d_dz", v), 32'(div_by_zero_o), 32'(vecs[v].dz));
            check($sformatf("v%0d_idle_busy", v), 32'(busy_o), 32'd0);
        end

        // Second start while busy is ignored
        run_div(1'b0, 32'd100, 32'd7, 5, lat, nd);
        check("busy_start_latency", 32'(lat), 32'd32);
        check("busy_start_done_count", 32'(nd), 32'd1);
        check("busy_start_q", quotient_o, 32'd14);
        check("busy_start_r", remainder_o, 32'd2);

        // Reset at edge N+10 aborts the divide
        @(negedge clk_i);
        signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_q", quotient_o, 32'd0);
        check("abort_r", remainder_o, 32'd0);
        check("abort_dz", 32'(div_by_zero_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
            if (done_o) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 0, lat, nd);
        check("after_abort_latency", 32'(lat), 32'd32);
        check("after_abort_q", quotient_o, 32'd3);
        check("after_abort_r", remainder_o, 32'd0);

        // Reset wins over start on the same edge
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
        @(posedge clk_i); #1;
        check("rst_prio_busy", 32'(busy_o), 32'd0);
        check("rst_prio_q", quotient_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_prio_idle", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
